// File: rtl/pkg_semaforo.sv
// Shared types and constants for the traffic-light timer: BCD digit, timer FSM states, default preset tables.
package pkg_semaforo;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONTANDO = 2'd1,
    FIM      = 2'd2
  } estado_tmp_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Entry 0 in the LSBs: phases 0..3 = 10,15,30,05 (normal) and 10,22,00,05 (special).
  localparam logic [31:0] PRESET_NORMAL_DEF = {8'h05, 8'h30, 8'h15, 8'h10};
  localparam logic [31:0] PRESET_ESP_DEF    = {8'h05, 8'h00, 8'h22, 8'h10};

  function automatic bcd_t sat_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/tabela_preset.sv
// Combinational per-phase preset lookup; picks the normal or special table and clamps any
// non-decimal digit to 9 so the counter never starts from an illegal BCD value.
module tabela_preset
  import pkg_semaforo::*;
#(
  parameter int                        EST_W         = 2,
  parameter logic [8*(2**EST_W)-1:0]   PRESET_NORMAL = PRESET_NORMAL_DEF,
  parameter logic [8*(2**EST_W)-1:0]   PRESET_ESP    = PRESET_ESP_DEF
) (
  input  logic [EST_W-1:0] estado,
  input  logic             caso_esp,
  output bcd_t             dez_preset,
  output bcd_t             unid_preset
);

  logic [7:0] entrada;

  always_comb begin
    entrada = caso_esp ? PRESET_ESP[{estado, 3'b000} +: 8]
                       : PRESET_NORMAL[{estado, 3'b000} +: 8];
  end

  assign dez_preset  = sat_bcd(entrada[7:4]);
  assign unid_preset = sat_bcd(entrada[3:0]);

endmodule

// File: rtl/temporizador_preset.sv
// Two-digit BCD down-counter timer: reloads a per-phase preset on phase change or explicit load,
// counts down one step per unpaused tick and pulses fim once on reaching 00.
module temporizador_preset
  import pkg_semaforo::*;
#(
  parameter int                        EST_W         = 2,
  parameter logic [8*(2**EST_W)-1:0]   PRESET_NORMAL = PRESET_NORMAL_DEF,
  parameter logic [8*(2**EST_W)-1:0]   PRESET_ESP    = PRESET_ESP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [EST_W-1:0] estado,
  input  logic             caso_esp,
  input  logic             carregar,
  input  logic             tick,
  input  logic             pausa,
  output bcd_t             dez,
  output bcd_t             unid,
  output logic             ativo,
  output logic             fim
);

  estado_tmp_t      st, st_n;
  logic [EST_W-1:0] estado_reg;
  bcd_t             dez_p, unid_p, dez_n, unid_n;
  logic             fim_n;
  logic             carga, preset_zero, passo, chega_zero, em_zero;

  tabela_preset #(
    .EST_W         (EST_W),
    .PRESET_NORMAL (PRESET_NORMAL),
    .PRESET_ESP    (PRESET_ESP)
  ) u_tabela (
    .estado      (estado),
    .caso_esp    (caso_esp),
    .dez_preset  (dez_p),
    .unid_preset (unid_p)
  );

  assign carga       = carregar || (estado != estado_reg);
  assign preset_zero = (dez_p == 4'd0) && (unid_p == 4'd0);
  assign passo       = tick && !pausa;
  assign chega_zero  = (dez == 4'd0) && (unid == 4'd1);
  assign em_zero     = (dez == 4'd0) && (unid == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= OCIOSO;
      estado_reg <= '0;
      dez        <= '0;
      unid       <= '0;
      ativo      <= 1'b0;
      fim        <= 1'b0;
    end else begin
      st         <= st_n;
      estado_reg <= estado;
      dez        <= dez_n;
      unid       <= unid_n;
      ativo      <= (st_n == CONTANDO);
      fim        <= fim_n;
    end
  end

  // A load event overrides everything else, including a coincident tick.
  always_comb begin
    st_n = st;
    if (carga) begin
      st_n = preset_zero ? FIM : CONTANDO;
    end else begin
      case (st)
        CONTANDO: if (passo && chega_zero) st_n = FIM;
        default:  st_n = st;
      endcase
    end
  end

  always_comb begin
    dez_n  = dez;
    unid_n = unid;
    fim_n  = 1'b0;
    if (carga) begin
      dez_n  = dez_p;
      unid_n = unid_p;
      fim_n  = preset_zero;
    end else if ((st == CONTANDO) && passo && !em_zero) begin
      if (unid != 4'd0) begin
        unid_n = unid - 4'd1;
      end else begin
        unid_n = BCD_MAX;
        dez_n  = dez - 4'd1;
      end
      fim_n = chega_zero;
    end
  end

endmodule

// File: tb/tb_temporizador_preset.sv
// Bench for temporizador_preset: default-table instance plus one with a non-decimal entry 0 (8'hAF).
module tb_temporizador_preset;

  logic       clk;
  logic       reset;
  logic [1:0] estado;
  logic       caso_esp;
  logic       carregar;
  logic       tick;
  logic       pausa;

  logic [3:0] dez  [2];
  logic [3:0] unid [2];
  logic       ativo[2];
  logic       fim  [2];

  int checks = 0;
  int errors = 0;

  temporizador_preset u_dut (
    .clk      (clk),
    .reset    (reset),
    .estado   (estado),
    .caso_esp (caso_esp),
    .carregar (carregar),
    .tick     (tick),
    .pausa    (pausa),
    .dez      (dez[0]),
    .unid     (unid[0]),
    .ativo    (ativo[0]),
    .fim      (fim[0])
  );

  temporizador_preset #(
    .EST_W         (2),
    .PRESET_NORMAL (32'h053015AF)
  ) u_sat (
    .clk      (clk),
    .reset    (reset),
    .estado   (estado),
    .caso_esp (caso_esp),
    .carregar (carregar),
    .tick     (tick),
    .pausa    (pausa),
    .dez      (dez[1]),
    .unid     (unid[1]),
    .ativo    (ativo[1]),
    .fim      (fim[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: timer value as a plain integer in seconds.
  typedef struct {
    int val;
    bit run;
    bit fim;
    int est_reg;
  } mdl_t;

  mdl_t        m[2];
  logic [31:0] tbl_n[2];
  logic [31:0] tbl_e;
  bit          seen = 1'b0;

  initial begin
    tbl_n[0] = 32'h05301510;
    tbl_n[1] = 32'h053015AF;
    tbl_e    = 32'h05002210;
    for (int i = 0; i < 2; i++) begin
      m[i].val = 0; m[i].run = 1'b0; m[i].fim = 1'b0; m[i].est_reg = 0;
    end
  end

  function automatic int preset_val(logic [31:0] t, logic [1:0] idx);
    logic [7:0] b;
    int d, u;
    b = t[int'(idx)*8 +: 8];
    d = int'(b[7:4]);
    u = int'(b[3:0]);
    if (d > 9) d = 9;
    if (u > 9) u = 9;
    return d * 10 + u;
  endfunction

  function automatic mdl_t nxt(mdl_t s, logic [31:0] tn);
    mdl_t r;
    int   p;
    r = s;
    if (reset) begin
      r.val = 0; r.run = 1'b0; r.fim = 1'b0; r.est_reg = 0;
      return r;
    end
    r.fim = 1'b0;
    if (carregar || (int'(estado) != s.est_reg)) begin
      p     = preset_val(caso_esp ? tbl_e : tn, estado);
      r.val = p;
      r.run = (p != 0);
      r.fim = (p == 0);
    end else if (s.run && tick && !pausa) begin
      r.val = s.val - 1;
      if (r.val == 0) begin
        r.run = 1'b0;
        r.fim = 1'b1;
      end
    end
    r.est_reg = int'(estado);
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) m[i] <= nxt(m[i], tbl_n[i]);
    seen <= 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (seen) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("dut%0d_dez", i),   int'(dez[i]),   m[i].val / 10);
        chk($sformatf("dut%0d_unid", i),  int'(unid[i]),  m[i].val % 10);
        chk($sformatf("dut%0d_ativo", i), int'(ativo[i]), int'(m[i].run));
        chk($sformatf("dut%0d_fim", i),   int'(fim[i]),   int'(m[i].fim));
        chk($sformatf("dut%0d_bcd_legal", i), int'((dez[i] <= 4'd9) && (unid[i] <= 4'd9)), 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic lit(input string name, input int i, input logic [7:0] exp);
    chk(name, int'({dez[i], unid[i]}), int'(exp));
  endtask

  initial begin
    reset = 1'b1; estado = 2'd0; caso_esp = 1'b0;
    carregar = 1'b0; tick = 1'b0; pausa = 1'b0;
    step(); step();
    lit("reset_val", 0, 8'h00);
    chk("reset_ativo", int'(ativo[0]), 0);
    chk("reset_fim", int'(fim[0]), 0);

    reset = 1'b0;
    step();
    lit("idle_val", 0, 8'h00);
    chk("idle_ativo", int'(ativo[0]), 0);

    // Phase 0 -> 1: load 15, count to 00.
    estado = 2'd1;
    step();
    lit("t1_load", 0, 8'h15);
    chk("t1_ativo", int'(ativo[0]), 1);
    repeat (14) tick1();
    lit("t1_01", 0, 8'h01);
    chk("t1_fim_early", int'(fim[0]), 0);
    tick1();
    lit("t1_00", 0, 8'h00);
    chk("t1_fim", int'(fim[0]), 1);
    chk("t1_ativo_off", int'(ativo[0]), 0);
    tick1();
    lit("t1_hold", 0, 8'h00);
    chk("t1_fim_once", int'(fim[0]), 0);

    // Special preset 00: straight to FIM.
    caso_esp = 1'b1; estado = 2'd2;
    step();
    lit("t2_val", 0, 8'h00);
    chk("t2_fim", int'(fim[0]), 1);
    chk("t2_ativo", int'(ativo[0]), 0);
    step();
    chk("t2_fim_once", int'(fim[0]), 0);

    // Tens borrow.
    caso_esp = 1'b0; estado = 2'd0;
    step();
    lit("t3_load10", 0, 8'h10);
    lit("t3_sat99", 1, 8'h99);
    tick1();
    lit("t3_09", 0, 8'h09);
    estado = 2'd2;
    step();
    lit("t3_30", 0, 8'h30);
    repeat (10) tick1();
    lit("t3_20", 0, 8'h20);
    repeat (10) tick1();
    lit("t3_10", 0, 8'h10);

    // Load and tick together at 07: reload wins.
    repeat (3) tick1();
    lit("t4_07", 0, 8'h07);
    estado = 2'd3; carregar = 1'b1; tick = 1'b1;
    step();
    carregar = 1'b0; tick = 1'b0;
    lit("t4_reload05", 0, 8'h05);

    // Pause holds; caso_esp change mid-count has no effect.
    estado = 2'd1;
    step();
    repeat (3) tick1();
    lit("t5_12", 0, 8'h12);
    pausa = 1'b1; caso_esp = 1'b1;
    repeat (5) tick1();
    lit("t5_paused", 0, 8'h12);
    pausa = 1'b0;
    repeat (2) tick1();
    lit("t5_10", 0, 8'h10);
    caso_esp = 1'b0;

    // Reset mid-count, then auto-load for current phase.
    repeat (2) tick1();
    lit("t6_08", 0, 8'h08);
    reset = 1'b1;
    step();
    reset = 1'b0;
    lit("t6_reset", 0, 8'h00);
    chk("t6_reset_ativo", int'(ativo[0]), 0);
    chk("t6_reset_fim", int'(fim[0]), 0);
    step();
    lit("t6_autoload", 0, 8'h15);
    chk("t6_ativo", int'(ativo[0]), 1);

    step(); step();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
